// File: rtl/memory_stage_pkg.sv
// Shared encodings for the memory stage: RV32I load/store funct3 codes,
// mcause values raised by the stage, and the access FSM states.
package memory_stage_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] CAUSE_ILLEGAL_INSN     = 4'd2;
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_ACCESS      = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_STORE_ACCESS     = 4'd7;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    function automatic logic funct3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        if (is_store) begin
            case (f3)
                F3_SB, F3_SH, F3_SW: ok = 1'b1;
                default:             ok = 1'b0;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
                default:                             ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/memory_stage_mem_align.sv
// Combinational byte-lane steering for RV32I loads/stores: store strobes and
// replicated data, load extraction with extension, misalign/illegal flags.
module mem_align
    import memory_stage_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic        i_is_store,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rs2,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic        o_misalign,
    output logic        o_illegal
);

    logic [31:0] shifted_s;

    // Lane steering, alignment check and load extension.
    always_comb begin
        shifted_s   = i_rdata >> {i_addr_lo, 3'b000};
        o_wstrb     = 4'b0000;
        o_wdata     = 32'h0000_0000;
        o_misalign  = 1'b0;
        o_load_data = 32'h0000_0000;
        o_illegal   = !funct3_legal(i_funct3, i_is_store);

        case (i_funct3[1:0])
            2'b00: begin
                o_wstrb    = 4'b0001 << i_addr_lo;
                o_wdata    = {4{i_rs2[7:0]}};
                o_misalign = 1'b0;
            end
            2'b01: begin
                o_wstrb    = 4'b0011 << i_addr_lo;
                o_wdata    = {2{i_rs2[15:0]}};
                o_misalign = i_addr_lo[0];
            end
            2'b10: begin
                o_wstrb    = 4'b1111;
                o_wdata    = i_rs2;
                o_misalign = (i_addr_lo != 2'b00);
            end
            default: begin
                o_wstrb    = 4'b0000;
                o_wdata    = 32'h0000_0000;
                o_misalign = 1'b0;
            end
        endcase

        case (i_funct3)
            F3_LB:   o_load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            F3_LH:   o_load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            F3_LW:   o_load_data = shifted_s;
            F3_LBU:  o_load_data = {24'h00_0000, shifted_s[7:0]};
            F3_LHU:  o_load_data = {16'h0000, shifted_s[15:0]};
            default: o_load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// RV32I memory stage: issues one req/ack data-memory access per load/store,
// detects misalignment, illegal widths and bus timeout, one result per instruction.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [2:0]      i_funct3,
    input  logic            i_mem_read,
    input  logic            i_mem_write,
    input  logic [4:0]      i_rd_addr,
    input  logic            i_reg_write,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    output logic [3:0]      o_dmem_wstrb,
    input  logic            i_dmem_ack,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic            o_valid,
    output logic [4:0]      o_rd_addr,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_reg_write,
    output logic            o_exc,
    output logic [3:0]      o_exc_cause,
    output logic [XLEN-1:0] o_exc_tval
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
    logic [31:0]       dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
    logic [3:0]        dmem_wstrb_q, dmem_wstrb_d;
    logic              valid_q, valid_d, reg_write_q, reg_write_d, exc_q, exc_d;
    logic [4:0]        rd_addr_q, rd_addr_d;
    logic [31:0]       rd_data_q, rd_data_d, exc_tval_q, exc_tval_d;
    logic [3:0]        exc_cause_q, exc_cause_d;
    // Context of the outstanding access, captured at accept.
    logic [2:0]        acc_funct3_q, acc_funct3_d;
    logic              acc_store_q, acc_store_d, acc_reg_write_q, acc_reg_write_d;
    logic [31:0]       acc_addr_q, acc_addr_d;

    logic              accept_s, in_mem_s, in_store_s;
    logic [2:0]        align_funct3_s;
    logic              align_store_s;
    logic [1:0]        align_lo_s;
    logic [3:0]        align_wstrb_s;
    logic [31:0]       align_wdata_s, align_load_s;
    logic              align_misalign_s, align_illegal_s;

    assign o_ready    = (state_q == ST_IDLE) && !i_rst;
    assign accept_s   = i_valid && o_ready;
    assign in_mem_s   = i_mem_read || i_mem_write;
    assign in_store_s = i_mem_write && !i_mem_read;

    // While idle the aligner sees the incoming op; during an access it sees the captured one.
    always_comb begin
        if (state_q == ST_IDLE) begin
            align_funct3_s = i_funct3;
            align_store_s  = in_store_s;
            align_lo_s     = i_alu_result[1:0];
        end else begin
            align_funct3_s = acc_funct3_q;
            align_store_s  = acc_store_q;
            align_lo_s     = acc_addr_q[1:0];
        end
    end

    mem_align u_align (
        .i_funct3    (align_funct3_s),
        .i_is_store  (align_store_s),
        .i_addr_lo   (align_lo_s),
        .i_rs2       (i_rs2_data),
        .i_rdata     (i_dmem_rdata),
        .o_wstrb     (align_wstrb_s),
        .o_wdata     (align_wdata_s),
        .o_load_data (align_load_s),
        .o_misalign  (align_misalign_s),
        .o_illegal   (align_illegal_s)
    );

    // Next-state and next-output logic for the IDLE/ACCESS controller.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        dmem_req_d      = dmem_req_q;
        dmem_we_d       = dmem_we_q;
        dmem_addr_d     = dmem_addr_q;
        dmem_wdata_d    = dmem_wdata_q;
        dmem_wstrb_d    = dmem_wstrb_q;
        valid_d         = 1'b0;
        rd_addr_d       = rd_addr_q;
        rd_data_d       = rd_data_q;
        reg_write_d     = reg_write_q;
        exc_d           = exc_q;
        exc_cause_d     = exc_cause_q;
        exc_tval_d      = exc_tval_q;
        acc_funct3_d    = acc_funct3_q;
        acc_store_d     = acc_store_q;
        acc_reg_write_d = acc_reg_write_q;
        acc_addr_d      = acc_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    rd_addr_d = i_rd_addr;
                    if (!in_mem_s) begin
                        valid_d     = 1'b1;
                        rd_data_d   = i_alu_result;
                        reg_write_d = i_reg_write;
                        exc_d       = 1'b0;
                        exc_cause_d = 4'd0;
                        exc_tval_d  = 32'h0000_0000;
                    end else if (align_illegal_s) begin
                        valid_d     = 1'b1;
                        rd_data_d   = 32'h0000_0000;
                        reg_write_d = 1'b0;
                        exc_d       = 1'b1;
                        exc_cause_d = CAUSE_ILLEGAL_INSN;
                        exc_tval_d  = 32'h0000_0000;
                    end else if (align_misalign_s) begin
                        valid_d     = 1'b1;
                        rd_data_d   = 32'h0000_0000;
                        reg_write_d = 1'b0;
                        exc_d       = 1'b1;
                        exc_cause_d = in_store_s ? CAUSE_STORE_MISALIGNED : CAUSE_LOAD_MISALIGNED;
                        exc_tval_d  = i_alu_result;
                    end else begin
                        state_d         = ST_ACCESS;
                        cnt_d           = '0;
                        dmem_req_d      = 1'b1;
                        dmem_we_d       = in_store_s;
                        dmem_addr_d     = {i_alu_result[31:2], 2'b00};
                        dmem_wdata_d    = in_store_s ? align_wdata_s : 32'h0000_0000;
                        dmem_wstrb_d    = in_store_s ? align_wstrb_s : 4'b0000;
                        acc_funct3_d    = i_funct3;
                        acc_store_d     = in_store_s;
                        acc_reg_write_d = i_reg_write && !in_store_s;
                        acc_addr_d      = i_alu_result;
                    end
                end else begin
                    valid_d = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (i_dmem_ack) begin
                    state_d     = ST_IDLE;
                    dmem_req_d  = 1'b0;
                    valid_d     = 1'b1;
                    rd_data_d   = acc_store_q ? 32'h0000_0000 : align_load_s;
                    reg_write_d = acc_reg_write_q;
                    exc_d       = 1'b0;
                    exc_cause_d = 4'd0;
                    exc_tval_d  = 32'h0000_0000;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_IDLE;
                    dmem_req_d  = 1'b0;
                    valid_d     = 1'b1;
                    rd_data_d   = 32'h0000_0000;
                    reg_write_d = 1'b0;
                    exc_d       = 1'b1;
                    exc_cause_d = acc_store_q ? CAUSE_STORE_ACCESS : CAUSE_LOAD_ACCESS;
                    exc_tval_d  = acc_addr_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                dmem_req_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs, cleared by synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            dmem_req_q      <= 1'b0;
            dmem_we_q       <= 1'b0;
            dmem_addr_q     <= 32'h0000_0000;
            dmem_wdata_q    <= 32'h0000_0000;
            dmem_wstrb_q    <= 4'b0000;
            valid_q         <= 1'b0;
            rd_addr_q       <= 5'd0;
            rd_data_q       <= 32'h0000_0000;
            reg_write_q     <= 1'b0;
            exc_q           <= 1'b0;
            exc_cause_q     <= 4'd0;
            exc_tval_q      <= 32'h0000_0000;
            acc_funct3_q    <= 3'b000;
            acc_store_q     <= 1'b0;
            acc_reg_write_q <= 1'b0;
            acc_addr_q      <= 32'h0000_0000;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            dmem_req_q      <= dmem_req_d;
            dmem_we_q       <= dmem_we_d;
            dmem_addr_q     <= dmem_addr_d;
            dmem_wdata_q    <= dmem_wdata_d;
            dmem_wstrb_q    <= dmem_wstrb_d;
            valid_q         <= valid_d;
            rd_addr_q       <= rd_addr_d;
            rd_data_q       <= rd_data_d;
            reg_write_q     <= reg_write_d;
            exc_q           <= exc_d;
            exc_cause_q     <= exc_cause_d;
            exc_tval_q      <= exc_tval_d;
            acc_funct3_q    <= acc_funct3_d;
            acc_store_q     <= acc_store_d;
            acc_reg_write_q <= acc_reg_write_d;
            acc_addr_q      <= acc_addr_d;
        end
    end

    assign o_dmem_req   = dmem_req_q;
    assign o_dmem_we    = dmem_we_q;
    assign o_dmem_addr  = dmem_addr_q;
    assign o_dmem_wdata = dmem_wdata_q;
    assign o_dmem_wstrb = dmem_wstrb_q;
    assign o_valid      = valid_q;
    assign o_rd_addr    = rd_addr_q;
    assign o_rd_data    = rd_data_q;
    assign o_reg_write  = reg_write_q;
    assign o_exc        = exc_q;
    assign o_exc_cause  = exc_cause_q;
    assign o_exc_tval   = exc_tval_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: a reference model predicts each result
// from the ISA rules, a monitor compares every o_valid pulse against the queue.
module tb_memory_stage;

    localparam int TO = 4;

    logic        i_clk = 1'b0, i_rst = 1'b1, i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_alu_result = 32'h0, i_rs2_data = 32'h0;
    logic [2:0]  i_funct3 = 3'b000;
    logic        i_mem_read = 1'b0, i_mem_write = 1'b0, i_reg_write = 1'b0;
    logic [4:0]  i_rd_addr = 5'd0;
    logic        o_dmem_req, o_dmem_we;
    logic [31:0] o_dmem_addr, o_dmem_wdata;
    logic [3:0]  o_dmem_wstrb;
    logic        i_dmem_ack = 1'b0;
    logic [31:0] i_dmem_rdata = 32'h0;
    logic        o_valid, o_reg_write, o_exc;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data, o_exc_tval;
    logic [3:0]  o_exc_cause;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        rw;
        logic        exc;
        logic [3:0]  cause;
        logic [31:0] tval;
        logic        chk_data;
    } exp_t;

    exp_t exp_q[$];

    memory_stage #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_alu_result(i_alu_result), .i_rs2_data(i_rs2_data), .i_funct3(i_funct3),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_rd_addr(i_rd_addr),
        .i_reg_write(i_reg_write), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
        .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata), .o_dmem_wstrb(o_dmem_wstrb),
        .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata), .o_valid(o_valid),
        .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data), .o_reg_write(o_reg_write),
        .o_exc(o_exc), .o_exc_cause(o_exc_cause), .o_exc_tval(o_exc_tval)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Monitor: every result pulse must match the oldest prediction.
    always @(negedge i_clk) begin
        if (!i_rst && o_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("res_exc", {31'd0, o_exc}, {31'd0, e.exc});
                chk("res_reg_write", {31'd0, o_reg_write}, {31'd0, e.rw});
                if (e.exc) begin
                    chk("res_cause", {28'd0, o_exc_cause}, {28'd0, e.cause});
                    chk("res_tval", o_exc_tval, e.tval);
                end else begin
                    chk("res_rd_addr", {27'd0, o_rd_addr}, {27'd0, e.rd});
                    if (e.chk_data) chk("res_rd_data", o_rd_data, e.data);
                end
            end
        end
    end

    // kind: 0 non-mem, 1 load, 2 store, 3 read+write (behaves as load).
    // delay: ack arrives this many cycles after the first request cycle; >= TO never acks.
    task automatic run_op(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [31:0] rdata,
                          input logic [4:0] rd, input logic rw, input int delay);
        exp_t e;
        bit is_store, legal, bus;
        int nbytes, off, waited;
        logic [31:0] v, strobe, wdata;
        is_store = (kind == 2);
        e.rd = rd; e.data = 32'h0; e.rw = 1'b0; e.exc = 1'b0; e.cause = 4'd0;
        e.tval = 32'h0; e.chk_data = 1'b1;
        bus = 1'b0;
        nbytes = 1 << (f3 % 4);
        off = addr % 4;
        if (kind == 0) begin
            e.data = addr; e.rw = rw;
        end else begin
            legal = is_store ? (f3 < 3) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            if (!legal) begin
                e.exc = 1'b1; e.cause = 4'd2; e.tval = 32'h0;
            end else if ((addr % nbytes) != 0) begin
                e.exc = 1'b1; e.cause = is_store ? 4'd6 : 4'd4; e.tval = addr;
            end else begin
                bus = 1'b1;
                if (delay >= TO) begin
                    e.exc = 1'b1; e.cause = is_store ? 4'd7 : 4'd5; e.tval = addr;
                end else if (is_store) begin
                    e.chk_data = 1'b0;
                end else begin
                    v = rdata >> (8 * off);
                    if (nbytes < 4) begin
                        v = v & ((32'd1 << (8 * nbytes)) - 32'd1);
                        if (f3 < 4 && v[8 * nbytes - 1]) v = v | (32'hFFFF_FFFF << (8 * nbytes));
                    end
                    e.data = v; e.rw = rw;
                end
            end
        end
        strobe = ((32'd1 << nbytes) - 32'd1) << off;
        wdata = (nbytes == 1) ? rs2[7:0] * 32'h0101_0101 :
                (nbytes == 2) ? rs2[15:0] * 32'h0001_0001 : rs2;
        exp_q.push_back(e);

        i_valid = 1'b1; i_alu_result = addr; i_rs2_data = rs2; i_funct3 = f3;
        i_mem_read = (kind == 1 || kind == 3); i_mem_write = (kind == 2 || kind == 3);
        i_rd_addr = rd; i_reg_write = rw;
        waited = 0;
        while (!o_ready && waited < 20) begin
            @(posedge i_clk); #1; waited++;
        end
        if (!o_ready) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_alu_result = $urandom; i_rs2_data = $urandom; i_funct3 = 3'($urandom);

        if (!bus) begin
            chk("no_req", {31'd0, o_dmem_req}, 32'd0);
        end else begin
            chk("req_addr", o_dmem_addr, addr & 32'hFFFF_FFFC);
            chk("req_we", {31'd0, o_dmem_we}, {31'd0, is_store});
            if (is_store) begin
                chk("req_wstrb", {28'd0, o_dmem_wstrb}, strobe);
                chk("req_wdata", o_dmem_wdata, wdata);
            end
            for (int c = 0; c < TO; c++) begin
                chk("req_held", {31'd0, o_dmem_req}, 32'd1);
                chk("ready_low", {31'd0, o_ready}, 32'd0);
                chk("addr_stable", o_dmem_addr, addr & 32'hFFFF_FFFC);
                if (c == delay) begin
                    i_dmem_ack = 1'b1; i_dmem_rdata = rdata;
                end
                @(posedge i_clk); #1;
                i_dmem_ack = 1'b0; i_dmem_rdata = $urandom;
                if (c == delay) break;
            end
            chk("req_drop", {31'd0, o_dmem_req}, 32'd0);
            chk("ready_back", {31'd0, o_ready}, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_ready", {31'd0, o_ready}, 32'd0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_req", {31'd0, o_dmem_req}, 32'd0);
        chk("rst_addr", o_dmem_addr, 32'd0);
        chk("rst_rd_data", o_rd_data, 32'd0);
        chk("rst_exc", {27'd0, o_exc, o_exc_cause}, 32'd0);
        i_rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, o_ready}, 32'd1);

        // Directed cases.
        run_op(0, 3'b000, 32'h1234_5678, 32'h0, 32'h0, 5'd5, 1'b1, 0);
        run_op(1, 3'b000, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 5'd6, 1'b1, 0);
        run_op(1, 3'b100, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 5'd7, 1'b1, 0);
        run_op(2, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 32'h0, 5'd8, 1'b0, 2);
        run_op(1, 3'b010, 32'h0000_0201, 32'h0, 32'h0, 5'd9, 1'b1, 0);
        run_op(2, 3'b010, 32'h0000_0300, 32'h1111_2222, 32'h0, 5'd10, 1'b0, TO + 3);
        run_op(1, 3'b011, 32'h0000_0400, 32'h0, 32'h0, 5'd11, 1'b1, 0);
        run_op(2, 3'b100, 32'h0000_0400, 32'h0, 32'h0, 5'd12, 1'b0, 0);
        run_op(3, 3'b101, 32'h0000_0502, 32'h0, 32'hFEDC_8765, 5'd13, 1'b1, 1);
        run_op(1, 3'b010, 32'h0000_0600, 32'h0, 32'hCAFE_F00D, 5'd14, 1'b1, TO - 1);

        // Reset during an access, with a late ack after reset.
        i_valid = 1'b1; i_alu_result = 32'h0000_0700; i_funct3 = 3'b010;
        i_mem_read = 1'b1; i_mem_write = 1'b0; i_rd_addr = 5'd15; i_reg_write = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        chk("mid_rst_req_before", {31'd0, o_dmem_req}, 32'd1);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        chk("mid_rst_req", {31'd0, o_dmem_req}, 32'd0);
        chk("mid_rst_ready", {31'd0, o_ready}, 32'd0);
        i_rst = 1'b0; i_dmem_ack = 1'b1; i_dmem_rdata = 32'h5555_AAAA;
        #1;
        chk("mid_rst_ready_after", {31'd0, o_ready}, 32'd1);
        @(posedge i_clk); #1;
        i_dmem_ack = 1'b0;
        chk("late_ack_valid", {31'd0, o_valid}, 32'd0);
        chk("late_ack_req", {31'd0, o_dmem_req}, 32'd0);

        // Randomized mix.
        for (int n = 0; n < 250; n++) begin
            int kind, delay;
            logic [31:0] addr;
            kind = $urandom_range(0, 3);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            delay = ($urandom_range(0, 7) == 0) ? TO + 1 : $urandom_range(0, TO - 1);
            run_op(kind, 3'($urandom_range(0, 7)), addr, $urandom, $urandom,
                   5'($urandom), 1'($urandom), delay);
        end

        repeat (3) @(posedge i_clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of `execute`, upstream of writeback.
- Takes the ALU result and the store operand, and performs RV32I loads/stores over a simple req/ack data-memory port.
- Handles byte-lane alignment and sign/zero extension, misalignment detection and a bus timeout.
- Issues one registered result per instruction to writeback and stalls `execute` while a memory access is outstanding.

Parameters:
- XLEN, 32, datapath width (only 32 supported)
- TIMEOUT_CYCLES, 255, maximum cycles to wait for `i_dmem_ack` before raising an access fault (must be ≥1)

Ports:
- i_clk  in  1  CPU clock, all state on the rising edge
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  execute presents an instruction
- o_ready  out  1  stage can accept this cycle
- i_alu_result  in  32  effective address (mem op) or result (non-mem)
- i_rs2_data  in  32  store data
- i_funct3  in  3  load/store width code
- i_mem_read  in  1  instruction is a load
- i_mem_write  in  1  instruction is a store
- i_rd_addr  in  5  destination register
- i_reg_write  in  1  instruction writes rd
- o_dmem_req  out  1  bus request
- o_dmem_we  out  1  1 = write
- o_dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- o_dmem_wdata  out  32  lane-replicated store data
- o_dmem_wstrb  out  4  byte enables
- i_dmem_ack  in  1  transaction complete
- i_dmem_rdata  in  32  read word, valid with ack
- o_valid  out  1  one-cycle result pulse to writeback
- o_rd_addr  out  5  destination register
- o_rd_data  out  32  result / extended load data
- o_reg_write  out  1  write rd (forced 0 on exception)
- o_exc  out  1  exception with this result
- o_exc_cause  out  4  mcause code
- o_exc_tval  out  32  faulting byte address

Behaviour:
- Reset, synchronous (i_rst high at edge):
  - State goes to IDLE and the timeout counter clears.
  - All registered outputs go to 0: o_valid, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_wstrb, o_rd_addr, o_rd_data, o_reg_write, o_exc, o_exc_cause, o_exc_tval.
  - o_ready = (state==IDLE) && !i_rst.
- Reset mid-transaction: o_dmem_req drops on the next cycle and the late ack is ignored.
- Acceptance: on i_valid && o_ready. i_mem_read and i_mem_write both high → treated as load.
- FSM states: IDLE, ACCESS.
- IDLE, non-mem instruction: the next cycle has o_valid=1, o_rd_data=i_alu_result, rd/reg_write passed through (1-cycle latency, back-to-back throughput).
- IDLE, mem op, aligned → ACCESS:
  - o_dmem_req=1 from the next cycle.
  - addr/we/wdata/wstrb are registered at accept and held stable until ack.
- IDLE, mem op, misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0):
  - No bus request; the next cycle has o_valid=1, o_exc=1, o_exc_tval=address, o_reg_write=0.
  - Cause is 4 for a load, 6 for a store.
- Illegal funct3 (load 011/110/111; store ≥011): same as misaligned but with cause 2 and tval=0.
- ACCESS:
  - Ack in any cycle req is high, including the first → req drops next cycle, o_valid=1 next cycle, state→IDLE.
  - Counter increments each cycle without ack. When counter==TIMEOUT_CYCLES-1 and no ack → req drops, o_valid=1 with o_exc=1, cause 5 (load) / 7 (store), tval=address, o_reg_write=0.
  - Stores complete with o_reg_write=0.
- Store lanes:
  - SB: wstrb=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: wstrb=4'b0011<<addr[1:0], wdata={2{rs2[15:0]}}.
  - SW: wstrb=4'b1111, wdata=rs2.
- Load extract: shift rdata right by addr[1:0]*8.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Lane offset is captured at accept, not re-read at ack.
- Latency for an aligned mem op: accept at N, req at N+1, ack at M≥N+1, o_valid at M+1. o_ready=0 from N+1 through M.
- o_valid is a single-cycle pulse; writeback has no backpressure.

Decomposition:
- Shared header (header.vh) holds:
  - funct3 encodings: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - mcause codes: 2, 4, 5, 6, 7.
  - FSM state encodings.
- One combinational sub-module, mem_align: given funct3, addr[1:0], rs2 and rdata, it produces wstrb, wdata, load result and a misalign flag. It is reusable by a future store buffer.

Test Plan:
- Non-mem instruction, i_alu_result=0x1234_5678, rd=5 → one cycle later o_valid=1, o_rd_data=0x1234_5678, o_reg_write=1, no o_dmem_req.
- LB at addr 0x103, rdata=0x80AA_BBCC, ack on first req cycle → o_rd_data=0xFFFF_FF80. LBU at the same address → 0x0000_0080. o_dmem_addr=0x100.
- SH rs2=0xDEAD_BEEF at addr 0x202, ack after 3 cycles → wstrb=4'b1100, wdata=0xBEEF_BEEF. o_ready low for 3 cycles; o_valid with o_reg_write=0.
- LW at addr 0x201 → no req; next cycle o_exc=1, cause=4, tval=0x201, o_reg_write=0.
- TIMEOUT_CYCLES=4, SW never acked → req high exactly 4 cycles, then o_exc=1, cause=7, state IDLE, o_ready=1.
- i_rst asserted during ACCESS, then ack arrives → req=0 next cycle, no o_valid, o_ready=1 after reset release.
